// File: rtl/sum9_bcd.sv
// rtl/sum9_bcd.sv - 9-bit binary to 3-digit BCD converter (shift-and-add-3), optional SUM9_BCD_OVF_EN overflow flag
module sum9_bcd #(
    parameter int LEAD_BLANK = 0
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic       in_valid,
    input  logic [8:0] in_y,
    output logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_hund,
    output logic [3:0] out_tens,
    output logic [3:0] out_ones
`ifdef SUM9_BCD_OVF_EN
    ,
    output logic       out_ovf
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [11:0] bcd;
    logic [8:0]  bin;
    logic [11:0] adj;
    logic [11:0] bcd_nx;
    logic [8:0]  bin_nx;
    logic        hund_blank;
    logic        tens_blank;
`ifdef SUM9_BCD_OVF_EN
    logic        ovf_cap;
`endif

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        {bcd_nx, bin_nx} = {adj[10:0], bin, 1'b0};
    end

    // Blanking is decided on the post-shift value that lands in the outputs.
    always_comb begin
        hund_blank = (LEAD_BLANK != 0) && (bcd_nx[11:8] == 4'd0);
        tens_blank = hund_blank && (bcd_nx[7:4] == 4'd0);
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            bcd       <= 12'd0;
            bin       <= 9'd0;
            out_ready <= 1'b1;
            out_valid <= 1'b0;
            out_hund  <= 4'd0;
            out_tens  <= 4'd0;
            out_ones  <= 4'd0;
`ifdef SUM9_BCD_OVF_EN
            ovf_cap   <= 1'b0;
            out_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (in_valid) begin
                        bin       <= in_y;
                        bcd       <= 12'd0;
                        cnt       <= 4'd9;
                        out_valid <= 1'b0;
                        out_ready <= 1'b0;
                        state     <= SHIFT;
`ifdef SUM9_BCD_OVF_EN
                        ovf_cap   <= in_y[8];
`endif
                    end
                end
                SHIFT: begin
                    bcd <= bcd_nx;
                    bin <= bin_nx;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        out_hund  <= hund_blank ? 4'hF : bcd_nx[11:8];
                        out_tens  <= tens_blank ? 4'hF : bcd_nx[7:4];
                        out_ones  <= bcd_nx[3:0];
                        out_valid <= 1'b1;
                        out_ready <= 1'b1;
                        state     <= DONE;
`ifdef SUM9_BCD_OVF_EN
                        out_ovf   <= ovf_cap;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum9_bcd.sv
// tb/tb_sum9_bcd.sv - directed self-checking bench for sum9_bcd (plain and leading-blank instances)
module tb_sum9_bcd;

    logic       in_clk;
    logic       in_rst_n;
    logic       in_valid;
    logic [8:0] in_y;
    logic       d_ready, d_valid, b_ready, b_valid;
    logic [3:0] d_hund, d_tens, d_ones, b_hund, b_tens, b_ones;
`ifdef SUM9_BCD_OVF_EN
    logic       d_ovf, b_ovf;
`endif

    int tests = 0;
    int fails = 0;
    int lat;

    sum9_bcd #(.LEAD_BLANK(0)) u_dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_valid(in_valid), .in_y(in_y),
        .out_ready(d_ready), .out_valid(d_valid),
        .out_hund(d_hund), .out_tens(d_tens), .out_ones(d_ones)
`ifdef SUM9_BCD_OVF_EN
        , .out_ovf(d_ovf)
`endif
    );

    sum9_bcd #(.LEAD_BLANK(1)) u_blk (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_valid(in_valid), .in_y(in_y),
        .out_ready(b_ready), .out_valid(b_valid),
        .out_hund(b_hund), .out_tens(b_tens), .out_ones(b_ones)
`ifdef SUM9_BCD_OVF_EN
        , .out_ovf(b_ovf)
`endif
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks a completed result on both instances; blank expectations given as hand values.
    task automatic chk_res(input string tag, input int h, input int t, input int o,
                           input int bh, input int bt, input int ovf);
        chk({tag, ".valid"}, int'(d_valid), 1);
        chk({tag, ".ready"}, int'(d_ready), 1);
        chk({tag, ".hund"}, int'(d_hund), h);
        chk({tag, ".tens"}, int'(d_tens), t);
        chk({tag, ".ones"}, int'(d_ones), o);
        chk({tag, ".b_valid"}, int'(b_valid), 1);
        chk({tag, ".b_hund"}, int'(b_hund), bh);
        chk({tag, ".b_tens"}, int'(b_tens), bt);
        chk({tag, ".b_ones"}, int'(b_ones), o);
`ifdef SUM9_BCD_OVF_EN
        chk({tag, ".ovf"}, int'(d_ovf), ovf);
        chk({tag, ".b_ovf"}, int'(b_ovf), ovf);
`else
        if (ovf < 0) chk({tag, ".ovf_arg"}, ovf, 0);
`endif
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, int'(d_valid), 0);
        chk({tag, ".ready"}, int'(d_ready), 1);
        chk({tag, ".digits"}, int'({d_hund, d_tens, d_ones}), 0);
        chk({tag, ".b_valid"}, int'(b_valid), 0);
        chk({tag, ".b_ready"}, int'(b_ready), 1);
        chk({tag, ".b_digits"}, int'({b_hund, b_tens, b_ones}), 0);
`ifdef SUM9_BCD_OVF_EN
        chk({tag, ".ovf"}, int'(d_ovf), 0);
`endif
    endtask

    // Accepts y, optionally injects inj_y on lat==inj_at, and returns edges to out_valid.
    task automatic run(input logic [8:0] y, input int inj_at, input logic [8:0] inj_y,
                       output int n, output int ready_low);
        logic [11:0] held;
        held = {d_hund, d_tens, d_ones};
        ready_low = 0;
        in_valid = 1'b1;
        in_y = y;
        step();
        in_valid = 1'b0;
        in_y = 9'd0;
        n = 1;
        while (!d_valid && n < 40) begin
            if (!d_ready) ready_low++;
            chk("shift.hold", int'({d_hund, d_tens, d_ones}), int'(held));
            if (n == inj_at) begin
                in_valid = 1'b1;
                in_y = inj_y;
            end
            step();
            in_valid = 1'b0;
            in_y = 9'd0;
            n++;
        end
    endtask

    initial begin
        int rl;
        in_rst_n = 1'b0;
        in_valid = 1'b0;
        in_y = 9'd0;
        repeat (2) step();
        chk_reset("reset");

        in_rst_n = 1'b1;
        run(9'd0, -1, 9'd0, lat, rl);
        chk("y0.latency", lat, 10);
        chk_res("y0", 0, 0, 0, 15, 15, 0);

        run(9'd510, -1, 9'd0, lat, rl);
        chk("y510.latency", lat, 10);
        chk_res("y510", 5, 1, 0, 5, 1, 1);

        run(9'd255, -1, 9'd0, lat, rl);
        chk("y255.latency", lat, 10);
        chk("y255.ready_low", rl, 9);
        chk_res("y255", 2, 5, 5, 2, 5, 0);

        run(9'd511, -1, 9'd0, lat, rl);
        chk_res("y511", 5, 1, 1, 5, 1, 1);

        run(9'd99, 3, 9'd300, lat, rl);
        chk("y99.latency", lat, 10);
        chk_res("y99", 0, 9, 9, 15, 9, 0);
        repeat (3) step();
        chk_res("y99.hold", 0, 9, 9, 15, 9, 0);

        run(9'd128, -1, 9'd0, lat, rl);
        chk_res("y128", 1, 2, 8, 1, 2, 0);
        run(9'd7, -1, 9'd0, lat, rl);
        chk("y7.valid_low", lat - 1, 9);
        chk_res("y7", 0, 0, 7, 15, 15, 0);

        in_valid = 1'b1;
        in_y = 9'd400;
        step();
        in_valid = 1'b0;
        in_y = 9'd0;
        repeat (4) step();
        @(posedge in_clk);
        in_rst_n = 1'b0;
        #1;
        chk_reset("midreset");
        repeat (3) step();
        chk_reset("midreset.hold");
        in_rst_n = 1'b1;
        run(9'd400, -1, 9'd0, lat, rl);
        chk("y400.latency", lat, 10);
        chk_res("y400", 4, 0, 0, 4, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
